// File: rtl/instruction_fetch.sv
// Instruction fetch stage: streams words from a combinational instruction ROM into a
// valid/ready output register, with branch redirect and EBREAK halt handling.
module instruction_fetch #(
    parameter int          ROM_SIZE = 64,
    parameter int          ADDR_W   = $clog2(ROM_SIZE),
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rd,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {START, RUN, HALT} state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        load;

    // A redirect seen during START is dropped so the first fetch always comes from RESET_PC.
    assign redirect        = redirect_valid && (state != START);
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign load            = (state == RUN) && !redirect_valid && (!out_valid || out_ready);
    assign imem_addr       = pc[ADDR_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= START;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            START:   next_state = RUN;
            RUN: begin
                if (redirect_valid) begin
                    next_state = RUN;
                end else if (load && (imem_rd == EBREAK)) begin
                    next_state = HALT;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    next_state = RUN;
                end
            end
            default: next_state = START;
        endcase
    end

    always_comb begin
        halted = (state == HALT);
    end

    // Output register and PC; a stalled output holds its word and the PC stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 32'h0;
            fetch_count <= 32'h0;
        end else if (redirect) begin
            pc        <= redirect_target;
            out_valid <= 1'b0;
        end else if (load) begin
            out_instr   <= imem_rd;
            out_pc      <= pc;
            out_valid   <= 1'b1;
            pc          <= pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch stream.
module tb_instruction_fetch;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] rom [64];
    int errors = 0;
    int checks = 0;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .halted(halted), .fetch_count(fetch_count)
    );

    assign imem_rd = rom[imem_addr];

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 64; i++) begin
            rom[i] = $urandom;
            if (rom[i] == EBREAK) rom[i] = rom[i] ^ 32'h1;
        end
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h want 0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h want 0", out_pc); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", fetch_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
        checks++; if (imem_addr !== 6'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] want [3];
        want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL start_bubble: got %b want 0", out_valid); end
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (out_valid !== 1'b1 || out_instr !== want[k] || out_pc !== 32'(4 * k))
                begin errors++; $display("[TB] FAIL stream_%0d: got v=%b %h@%h want 1 %h@%h", k, out_valid, out_instr, out_pc, want[k], 32'(4 * k)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cycle();
        cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (out_valid !== 1'b1 || out_instr !== 32'h22 || out_pc !== 32'h4 || fetch_count !== 32'd2)
                begin errors++; $display("[TB] FAIL stall_%0d: got v=%b %h@%h n=%0d want 1 22@4 n=2", k, out_valid, out_instr, out_pc, fetch_count); end
        end
        out_ready = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h33 || out_pc !== 32'h8 || fetch_count !== 32'd3)
            begin errors++; $display("[TB] FAIL after_stall: got v=%b %h@%h n=%0d want 1 33@8 n=3", out_valid, out_instr, out_pc, fetch_count); end
    endtask

    task automatic test_redirect();
        do_reset();
        cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_000E;
        cycle();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || imem_addr !== 6'd3)
            begin errors++; $display("[TB] FAIL redirect_bubble: got v=%b addr=%0d want 0 3", out_valid, imem_addr); end
        cycle();
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h44 || out_pc !== 32'hC)
            begin errors++; $display("[TB] FAIL redirect_target: got v=%b %h@%h want 1 44@c", out_valid, out_instr, out_pc); end
    endtask

    task automatic test_start_redirect();
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || imem_addr !== 6'd0)
            begin errors++; $display("[TB] FAIL start_redirect: got v=%b addr=%0d want 0 0", out_valid, imem_addr); end
        cycle();
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h11 || out_pc !== 32'h0)
            begin errors++; $display("[TB] FAIL start_first: got v=%b %h@%h want 1 11@0", out_valid, out_instr, out_pc); end
    endtask

    task automatic test_ebreak();
        rom[2] = EBREAK;
        do_reset();
        cycle();
        cycle();
        cycle();
        checks++; if (out_valid !== 1'b1 || out_instr !== EBREAK || out_pc !== 32'h8 || halted !== 1'b1 || fetch_count !== 32'd3)
            begin errors++; $display("[TB] FAIL ebreak: got v=%b %h@%h h=%b n=%0d want 1 ebreak@8 h=1 n=3", out_valid, out_instr, out_pc, halted, fetch_count); end
        out_ready = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b1 || out_instr !== EBREAK || out_pc !== 32'h8)
            begin errors++; $display("[TB] FAIL halt_stall: got v=%b %h@%h want 1 ebreak@8", out_valid, out_instr, out_pc); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (out_valid !== 1'b0 || halted !== 1'b1 || fetch_count !== 32'd3)
                begin errors++; $display("[TB] FAIL halt_%0d: got v=%b h=%b n=%0d want 0 1 3", k, out_valid, halted, fetch_count); end
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL unhalt: got h=%b v=%b want 0 0", halted, out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h11 || out_pc !== 32'h0)
            begin errors++; $display("[TB] FAIL refetch: got v=%b %h@%h want 1 11@0", out_valid, out_instr, out_pc); end
        rom[2] = 32'h33;
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFC;
        cycle();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 6'd63 || out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL wrap_addr: got addr=%0d v=%b want 63 0", imem_addr, out_valid); end
        cycle();
        checks++; if (out_pc !== 32'hFC || out_instr !== rom[63] || imem_addr !== 6'd0)
            begin errors++; $display("[TB] FAIL wrap_fc: got %h@%h addr=%0d want %h@fc addr=0", out_instr, out_pc, imem_addr, rom[63]); end
        cycle();
        checks++; if (out_pc !== 32'h100 || out_instr !== 32'h11)
            begin errors++; $display("[TB] FAIL wrap_100: got %h@%h want 11@100", out_instr, out_pc); end
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        checks++; if (out_pc !== 32'hFFFF_FFFC || out_instr !== rom[63] || imem_addr !== 6'd0)
            begin errors++; $display("[TB] FAIL pc_top: got %h@%h addr=%0d want %h@fffffffc addr=0", out_instr, out_pc, imem_addr, rom[63]); end
        cycle();
        checks++; if (out_pc !== 32'h0 || out_instr !== 32'h11)
            begin errors++; $display("[TB] FAIL pc_wrap32: got %h@%h want 11@0", out_instr, out_pc); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        cycle();
        out_ready = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || fetch_count !== 32'h0 || out_pc !== 32'h0)
            begin errors++; $display("[TB] FAIL async_reset: got v=%b n=%0d pc=%h want 0 0 0", out_valid, fetch_count, out_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL restart_bubble: got v=%b want 0", out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h11 || out_pc !== 32'h0)
            begin errors++; $display("[TB] FAIL restart_first: got v=%b %h@%h want 1 11@0", out_valid, out_instr, out_pc); end
    endtask

    // Model: each cycle the stage either takes a redirect, emits the next word of the
    // program stream, or keeps showing the word the consumer has not yet accepted.
    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] item_pc = 32'h0;
        logic [31:0] item_instr = 32'h0;
        logic [31:0] target;
        logic        m_valid = 1'b0;
        logic        rdy;
        logic        red;
        int          m_count = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(3) != 0);
            red = ($urandom_range(7) == 0);
            target = $urandom;
            out_ready = rdy;
            redirect_valid = red;
            redirect_pc = target;
            cycle();
            if (red) begin
                m_valid = 1'b0;
                exp_pc = target - (target % 4);
            end else if (!m_valid || rdy) begin
                m_valid = 1'b1;
                item_pc = exp_pc;
                item_instr = rom[(exp_pc / 4) % 64];
                exp_pc = exp_pc + 4;
                m_count++;
            end
            checks++; if (out_valid !== m_valid || (m_valid && (out_pc !== item_pc || out_instr !== item_instr)))
                begin errors++; $display("[TB] FAIL rand_out_%0d: got v=%b %h@%h want v=%b %h@%h", i, out_valid, out_instr, out_pc, m_valid, item_instr, item_pc); end
            checks++; if (fetch_count !== 32'(m_count) || imem_addr !== 6'((exp_pc / 4) % 64) || halted !== 1'b0)
                begin errors++; $display("[TB] FAIL rand_state_%0d: got n=%0d addr=%0d h=%b want n=%0d addr=%0d h=0", i, fetch_count, imem_addr, halted, m_count, (exp_pc / 4) % 64); end
        end
        redirect_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        fill_rom();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_start_redirect();
        test_ebreak();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
